// File: rtl/key_event_queue.sv
// Decodes PS/2 code pairs into make events and queues {code, step} for the rotor datapath.
// Latency: an accepted make at edge N is visible at the FIFO head after edge N.
// Backpressure: out_valid/out_ready pop; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.
module key_event_queue #(
  parameter int DEPTH         = 8,
  parameter int STEP_W        = 6,
  parameter int STEP_MOD      = 26,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     kc_valid,
  input  logic [15:0]              keycode,
  input  logic                     mode,
  output logic                     out_valid,
  output logic [7:0]               out_code,
  output logic [STEP_W-1:0]        out_step,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [STEP_W-1:0]        step
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_HELD} dec_state_e;

  dec_state_e          state_q, state_d;
  logic [7:0]          held_q, held_d;
  logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
  logic                ovf_q, ovf_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [7:0]          mem_code [DEPTH];
  logic [STEP_W-1:0]   mem_step [DEPTH];

  logic is_prefix, is_break, is_make, same_held, accept;
  logic push_req, push, pop;

  // Classify the incoming code pair; F0/E0 in the latest byte are bare prefixes.
  always_comb begin
    is_prefix = (keycode[7:0] == 8'hF0) || (keycode[7:0] == 8'hE0);
    is_break  = !is_prefix && (keycode[15:8] == 8'hF0);
    is_make   = !is_prefix && !is_break;
    same_held = (state_q == S_HELD) && (keycode[7:0] == held_q);
    // A repeat of the held key is a typematic repeat, dropped when filtering.
    accept    = is_make && (!same_held || (FILTER_REPEAT == 0));
  end

  // Decoder next state: tracks the held key regardless of mode or FIFO space.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    if (kc_valid) begin
      if (is_make) begin
        state_d = S_HELD;
        held_d  = keycode[7:0];
      end else if (is_break && same_held) begin
        state_d = S_IDLE;
      end
    end
  end

  // FIFO pointer, overflow and step-counter next state.
  always_comb begin
    push_req = kc_valid && accept && !mode;
    pop      = out_valid && out_ready;
    // When full, a push only lands if the head is leaving in the same cycle.
    push     = push_req && (!full || pop);
    wr_d     = wr_q + {{AW{1'b0}}, push};
    rd_d     = rd_q + {{AW{1'b0}}, pop};
    ovf_d    = ovf_q | (push_req && full && !pop);
    step_d   = step_q;
    if (mode) begin
      step_d = '0;
    end else if (push) begin
      step_d = (step_q == STEP_W'(STEP_MOD - 1)) ? '0 : step_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      held_q  <= 8'h00;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      step_q  <= step_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_code[wr_q[AW-1:0]] <= keycode[7:0];
      mem_step[wr_q[AW-1:0]] <= step_q;
    end
  end

  // Occupancy comes from the pointer difference; the extra bit separates full from empty.
  always_comb begin
    level     = wr_q - rd_q;
    full      = (level == (AW+1)'(DEPTH));
    empty     = (level == '0);
    out_valid = !empty;
    out_code  = mem_code[rd_q[AW-1:0]];
    out_step  = mem_step[rd_q[AW-1:0]];
    overflow  = ovf_q;
    step      = step_q;
  end

endmodule
